// File: rtl/pc_seq_ctrl.sv
// Fetch/decode/execute sequencer that steers the PC and the instruction-memory handshake.
// PC strobes are registered out of EXEC, so they appear on the cycle after EXEC.
module pc_seq_ctrl #(
  parameter int DWIDTH   = 16,
  parameter int WAIT_MAX = 15,
  parameter int CW       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              zero_flag,
  output logic              mem_rd,
  output logic              pc_en,
  output logic [1:0]        pc_ctrl,
  output logic [7:0]        offset_addr,
  output logic              reg_we,
  output logic [DWIDTH-1:0] ir_out,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        err
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_BEQZ = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state_q, state_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [1:0]        err_q, err_d;
  logic              mem_rd_q, mem_rd_d;
  logic              pc_en_q, pc_en_d;
  logic [1:0]        pc_ctrl_q, pc_ctrl_d;
  logic [7:0]        offset_q, offset_d;
  logic              reg_we_q, reg_we_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic [3:0]        op;

  assign op = ir_q[15:12];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ir_d       = ir_q;
    err_d      = err_q;
    pc_en_d    = 1'b0;
    pc_ctrl_d  = 2'b00;
    reg_we_d   = 1'b0;
    offset_d   = offset_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        // A response on the last allowed wait cycle still wins over the timeout.
        if (mem_ready) begin
          ir_d       = mem_rdata;
          wait_cnt_d = '0;
          state_d    = S_DECODE;
        end else if (wait_cnt_q == CW'(WAIT_MAX)) begin
          err_d   = 2'b10;
          state_d = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (op == OP_NOP || op == OP_ALU || op == OP_BEQZ || op == OP_JMP || op == OP_HALT) begin
          state_d = S_EXEC;
        end else begin
          err_d   = 2'b01;
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        if (op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          pc_en_d = 1'b1;
          if (op == OP_JMP || (op == OP_BEQZ && zero_flag)) begin
            pc_ctrl_d = 2'b10;
            offset_d  = ir_q[7:0];
          end else begin
            pc_ctrl_d = 2'b01;
          end
          reg_we_d = (op == OP_ALU);
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    mem_rd_d = (state_d == S_FETCH);
    halted_d = (state_d == S_HALT);
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      ir_q       <= '0;
      err_q      <= 2'b00;
      mem_rd_q   <= 1'b0;
      pc_en_q    <= 1'b0;
      pc_ctrl_q  <= 2'b00;
      offset_q   <= '0;
      reg_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ir_q       <= ir_d;
      err_q      <= err_d;
      mem_rd_q   <= mem_rd_d;
      pc_en_q    <= pc_en_d;
      pc_ctrl_q  <= pc_ctrl_d;
      offset_q   <= offset_d;
      reg_we_q   <= reg_we_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

  assign mem_rd      = mem_rd_q;
  assign pc_en       = pc_en_q;
  assign pc_ctrl     = pc_ctrl_q;
  assign offset_addr = offset_q;
  assign reg_we      = reg_we_q;
  assign ir_out      = ir_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign err         = err_q;

endmodule
